alu_share_sched: RTL

Arbiter and sequencer that shares the single 16-bit add/subtract datapath (the `addersub_16` instance) among three requesters: program-counter unit (port 0), data-pointer unit (port 1), and cell-value unit (port 2). It grants one request per cycle, registers the winning operands, runs them through the adder in the following cycle, and returns a tagged, registered result with a zero flag.

---
 rtl/alu_share_sched.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/alu_share_sched.sv
// Shares one 16-bit add/subtract datapath among three requesters using a 3-stage pipeline:
// arbitrate, execute, respond. Define ALU_SHARE_SCHED_FIXED_PRIO_EN for fixed priority 0 > 1 > 2.

module addersub_16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_sub,
  output logic [15:0] o_y
);
  logic [15:0] w_b;

  // Subtraction is A + ~B + 1, so the carry-in is the sub flag itself.
  assign w_b = i_sub ? ~i_b : i_b;
  assign o_y = i_a + w_b + {15'd0, i_sub};
endmodule

module alu_share_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [47:0] req_a,
  input  logic [47:0] req_b,
  input  logic [2:0]  req_sub,
  input  logic        hold,
  output logic [2:0]  gnt,
  output logic [2:0]  rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_zero,
  output logic        busy
);
  logic [2:0]  w_pick;
  logic [1:0]  w_gnt_id;
  logic [15:0] w_sel_a;
  logic [15:0] w_sel_b;
  logic        w_sel_sub;
  logic [15:0] w_sum;

  logic        r_op_valid;
  logic [1:0]  r_op_id;
  logic [15:0] r_op_a;
  logic [15:0] r_op_b;
  logic        r_op_sub;

  logic [2:0]  r_rsp_valid;
  logic [15:0] r_rsp_data;
  logic        r_rsp_zero;

`ifdef ALU_SHARE_SCHED_FIXED_PRIO_EN
  always_comb begin
    if (req[0])      w_pick = 3'b001;
    else if (req[1]) w_pick = 3'b010;
    else if (req[2]) w_pick = 3'b100;
    else             w_pick = 3'b000;
  end
`else
  logic [1:0] r_last;

  // Search starts at the port after the last winner and ends at the last winner itself.
  always_comb begin
    w_pick = 3'b000;
    case (r_last)
      2'd0: begin
        if (req[1])      w_pick = 3'b010;
        else if (req[2]) w_pick = 3'b100;
        else if (req[0]) w_pick = 3'b001;
      end
      2'd1: begin
        if (req[2])      w_pick = 3'b100;
        else if (req[0]) w_pick = 3'b001;
        else if (req[1]) w_pick = 3'b010;
      end
      default: begin
        if (req[0])      w_pick = 3'b001;
        else if (req[1]) w_pick = 3'b010;
        else if (req[2]) w_pick = 3'b100;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_last <= 2'd2;
    else if (|gnt) r_last <= w_gnt_id;
  end
`endif

  assign gnt = (rst || hold) ? 3'b000 : w_pick;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_gnt_id  = 2'd0;
    w_sel_a   = req_a[15:0];
    w_sel_b   = req_b[15:0];
    w_sel_sub = req_sub[0];
    case (gnt)
      3'b010: begin
        w_gnt_id  = 2'd1;
        w_sel_a   = req_a[31:16];
        w_sel_b   = req_b[31:16];
        w_sel_sub = req_sub[1];
      end
      3'b100: begin
        w_gnt_id  = 2'd2;
        w_sel_a   = req_a[47:32];
        w_sel_b   = req_b[47:32];
        w_sel_sub = req_sub[2];
      end
      default: ;
    endcase
  end

  // NOTE: all pipeline state uses non-blocking assignments so stages advance in lockstep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_valid <= 1'b0;
      r_op_id    <= 2'd0;
      r_op_a     <= 16'h0000;
      r_op_b     <= 16'h0000;
      r_op_sub   <= 1'b0;
    end else begin
      r_op_valid <= |gnt;
      if (|gnt) begin
        r_op_id  <= w_gnt_id;
        r_op_a   <= w_sel_a;
        r_op_b   <= w_sel_b;
        r_op_sub <= w_sel_sub;
      end
    end
  end

  addersub_16 u_addersub (
    .i_a   (r_op_a),
    .i_b   (r_op_b),
    .i_sub (r_op_sub),
    .o_y   (w_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 3'b000;
      r_rsp_data  <= 16'h0000;
      r_rsp_zero  <= 1'b1;
    end else begin
      r_rsp_valid <= r_op_valid ? (3'b001 << r_op_id) : 3'b000;
      if (r_op_valid) begin
        r_rsp_data <= w_sum;
        r_rsp_zero <= (w_sum == 16'h0000);
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_zero  = r_rsp_zero;
  assign busy      = r_op_valid | (|r_rsp_valid);
endmodule
